// File: rtl/addac_pkg.sv
// rtl/addac_pkg.sv - shared types and defaults for the addac operation feeder
package addac_pkg;

  localparam int DEFAULT_DEPTH = 4;

  typedef struct packed {
    logic [3:0] a;
    logic       sel1;
    logic       sel0;
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/addac_feeder_if.sv
// rtl/addac_feeder_if.sv - upstream operation handshake into the feeder
interface addac_feeder_if;

  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a;
  logic       in_sel0;
  logic       in_sel1;

  modport master (
    output in_valid,
    output in_a,
    output in_sel0,
    output in_sel1,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_a,
    input  in_sel0,
    input  in_sel1,
    output in_ready
  );

endinterface

// File: rtl/addac_fifo.sv
// rtl/addac_fifo.sv - circular operation buffer; pushes at full and pops at empty are ignored
module addac_fifo
  import addac_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  op_t                    push_data_i,
  input  logic                   pop_i,
  output op_t                    pop_data_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH) + 1;

  op_t           mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [LW-1:0] level_q;
  logic          push_ok;
  logic          pop_ok;

  assign push_ok    = push_i && (level_q != LW'(DEPTH));
  assign pop_ok     = pop_i && (level_q != '0);
  assign pop_data_o = mem_q[rd_ptr_q];
  assign level_o    = level_q;

  // Storage needs no reset: pointers and level define which slots are live.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // DEPTH is a power of two, so pointers wrap naturally at their width.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/addac_feeder.sv
// rtl/addac_feeder.sv - buffers addac operations and issues them one per cycle on start
module addac_feeder
  import addac_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  addac_feeder_if.slave          up,
  input  logic                   start,
  output logic [3:0]             a,
  output logic                   sel0,
  output logic                   sel1,
  output logic                   op_valid,
  output logic                   busy,
  output logic                   done,
  output logic [$clog2(DEPTH):0] level,
  output logic [7:0]             issued
);

  localparam int LW = $clog2(DEPTH) + 1;

  state_e        state_q, state_d;
  op_t           op_q, op_d;
  logic          op_valid_q, op_valid_d;
  logic [7:0]    issued_q, issued_d;
  logic [LW-1:0] level_w;
  logic          push;
  logic          pop;
  op_t           push_data;
  op_t           pop_data;

  assign up.in_ready = (level_w < LW'(DEPTH));
  assign push        = up.in_valid && up.in_ready;
  assign push_data   = '{a: up.in_a, sel1: up.in_sel1, sel0: up.in_sel0};

  addac_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .pop_data_o  (pop_data),
    .level_o     (level_w)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    op_valid_d = 1'b0;
    issued_d   = issued_q;
    pop        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (level_w != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        // Entries pushed during the run keep it alive until the buffer drains.
        if (level_w != '0) begin
          pop        = 1'b1;
          op_d       = pop_data;
          op_valid_d = 1'b1;
          issued_d   = issued_q + 8'd1;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      op_valid_q <= 1'b0;
      issued_q   <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      op_valid_q <= op_valid_d;
      issued_q   <= issued_d;
    end
  end

  assign a        = op_q.a;
  assign sel0     = op_q.sel0;
  assign sel1     = op_q.sel1;
  assign op_valid = op_valid_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign level    = level_w;
  assign issued   = issued_q;

endmodule

// File: doc/addac_feeder.md
ADDAC_FEEDER -- requirements
Module: addac_feeder

Interface
REQ-001 Parameter DEPTH, default 4, number of operation entries buffered (power of two, 2..16).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset: one clock, synchronous, active-low (rst=0 resets on the next rising edge of clk).
REQ-004 in_valid  input  1  upstream offers an operation this cycle.
REQ-005 in_ready  output  1  feeder can accept an operation this cycle.
REQ-006 in_a  input  4  operand for the addac stage.
REQ-007 in_sel0, in_sel1  input  1 each  operation selects for the addac stage.
REQ-008 start  input  1  single-cycle request to issue all buffered operations.
REQ-009 a  output  4  operand driven to addac.
REQ-010 sel0, sel1  output  1 each  selects driven to addac.
REQ-011 op_valid  output  1  a/sel0/sel1 carry a newly issued operation this cycle.
REQ-012 busy  output  1  high in RUN or DONE.
REQ-013 done  output  1  one-cycle pulse after the last operation of a run issues.
REQ-014 level  output  $clog2(DEPTH)+1  current number of buffered entries.
REQ-015 issued  output  8  total operations issued since reset.

Function
REQ-016 Push: an entry {in_a, in_sel1, in_sel0} SHALL be written when in_valid && in_ready at a rising edge.
REQ-017 in_ready SHALL equal (level < DEPTH), independent of in_valid; no bypass from input to outputs.
REQ-018 FSM states SHALL be IDLE, RUN, DONE.
REQ-019 IDLE: start=1 at an edge SHALL move to RUN if level>0, else to DONE directly (zero-operation run).
REQ-020 RUN: at each edge with level>0 the oldest entry SHALL be popped into a/sel0/sel1 registers and op_valid set to 1 for the following cycle.
REQ-021 RUN: at an edge with level=0 the FSM SHALL move to DONE; op_valid 0.
REQ-022 DONE: done=1 for exactly that one cycle; next edge returns to IDLE.
REQ-023 Latency: start sampled at edge k with n entries SHALL give op_valid=1 after edges k+1..k+n and done=1 after edge k+n+1.
REQ-024 a/sel0/sel1 SHALL hold their last issued value when op_valid=0.
REQ-025 start SHALL be ignored in RUN and DONE.
REQ-026 Pushes during RUN SHALL be accepted per REQ-017 and issued in the same run if they arrive before the FIFO drains.
REQ-027 Simultaneous push and pop: level unchanged; data order strictly FIFO.
REQ-028 Push when level=DEPTH SHALL be dropped (in_ready=0); no overwrite.
REQ-029 issued SHALL increment by 1 per pop and wrap 255 -> 0.
REQ-030 FIFO read/write pointers SHALL wrap modulo DEPTH.

Reset
REQ-031 rst=0 at an edge SHALL set FSM=IDLE, level=0, pointers=0, a=0, sel0=0, sel1=0, op_valid=0, done=0, busy=0, issued=0.
REQ-032 Reset mid-run SHALL discard all buffered entries; no further op_valid until new pushes and start.
REQ-033 Reset SHALL take priority over start, push and pop in the same cycle.

Structure
REQ-034 Package addac_pkg SHALL hold the op struct typedef {a[3:0], sel1, sel0}, the state enum and default DEPTH.
REQ-035 One sub-module addac_fifo (parameterised DEPTH, op struct data, push/pop/level) SHALL implement the buffer; FSM and counters in addac_feeder.

Verification
REQ-036 Reset: rst=0 two cycles -> all outputs 0, in_ready=1, level=0.
REQ-037 Push ops (a=3,s0=1,s1=0),(a=9,0,1),(a=15,1,1), start -> op_valid on 3 consecutive cycles with a=3,9,15 in order, done one cycle later, issued=3.
REQ-038 Push 5 ops with DEPTH=4 -> 5th dropped, in_ready=0 at level=4; run issues exactly 4.
REQ-039 start with empty FIFO -> done after 1 edge, op_valid never 1, issued unchanged.
REQ-040 Push every cycle during a 4-entry run -> level stays constant during simultaneous push/pop, all entries issued in order, done only after FIFO empties.
REQ-041 rst=0 after second op of a 4-op run -> op_valid 0, level=0, issued=0; then 300 single-op runs -> issued wraps to 44.
